// File: rtl/dcache_refill_ctrl.sv
// D-cache line refill engine: issues an AHB-Lite WRAP4 read burst (critical word first),
// writes every returned beat into the data SRAM and forwards the critical word to the load path.
module dcache_refill_ctrl #(
  parameter int INDEX_WIDTH     = 7,
  parameter int SRAM_ADDR_WIDTH = 9,
  parameter int LINE_WORDS      = 4
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic                       miss_req,
  input  logic [31:0]                miss_addr,
  output logic                       miss_ack,
  output logic                       busy,
  output logic                       fill_word_valid,
  output logic [31:0]                fill_word,
  output logic                       fill_done,
  output logic                       fill_err,
  output logic [31:0]                HADDR,
  output logic [1:0]                 HTRANS,
  output logic [2:0]                 HBURST,
  output logic [2:0]                 HSIZE,
  output logic                       HWRITE,
  input  logic                       HREADY,
  input  logic                       HRESP,
  input  logic [31:0]                HRDATA,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [31:0]                sram_wr_data,
  output logic                       sram_wr_en,
  output logic [3:0]                 sram_wr_byte_en
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [1:0] LAST_BEAT     = 2'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DRAIN,
    ST_ABORT
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  beat_q, beat_d;         // address-phase beat k
  logic [27:0] addr_hi_q, addr_hi_d;   // miss_addr[31:4]
  logic [1:0]  w0_q, w0_d;             // critical word offset
  logic        dp_valid_q, dp_valid_d; // a data phase is outstanding
  logic [1:0]  dp_beat_q, dp_beat_d;   // beat j of that data phase
  logic        wr_en_q, wr_en_d;
  logic [1:0]  wr_word_q, wr_word_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        fw_valid_q, fw_valid_d;
  logic [31:0] fill_word_q, fill_word_d;
  logic        done_q, done_d;

  logic data_ok;
  logic data_err;
  logic unused_addr_bits;

  assign data_ok          = dp_valid_q && HREADY && !HRESP;
  // First cycle of the two-cycle AHB error response.
  assign data_err         = dp_valid_q && HRESP && !HREADY;
  assign unused_addr_bits = ^miss_addr[1:0];

  // NOTE: sequential state uses non-blocking assignments only; all next-state math lives in
  // the combinational process so every register here is a plain copy of its _d.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      addr_hi_q   <= '0;
      w0_q        <= '0;
      dp_valid_q  <= 1'b0;
      dp_beat_q   <= '0;
      wr_en_q     <= 1'b0;
      // NOTE: datapath registers are reset too, so every output reads 0 straight out of reset.
      wr_word_q   <= '0;
      wr_data_q   <= '0;
      fw_valid_q  <= 1'b0;
      fill_word_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      addr_hi_q   <= addr_hi_d;
      w0_q        <= w0_d;
      dp_valid_q  <= dp_valid_d;
      dp_beat_q   <= dp_beat_d;
      wr_en_q     <= wr_en_d;
      wr_word_q   <= wr_word_d;
      wr_data_q   <= wr_data_d;
      fw_valid_q  <= fw_valid_d;
      fill_word_q <= fill_word_d;
      done_q      <= done_d;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    addr_hi_d   = addr_hi_q;
    w0_d        = w0_q;
    dp_valid_d  = dp_valid_q;
    dp_beat_d   = dp_beat_q;
    wr_en_d     = 1'b0;
    wr_word_d   = wr_word_q;
    wr_data_d   = wr_data_q;
    fw_valid_d  = 1'b0;
    fill_word_d = fill_word_q;
    done_d      = 1'b0;

    if (data_ok) begin
      dp_valid_d = 1'b0;
      wr_en_d    = 1'b1;
      wr_word_d  = w0_q + dp_beat_q;
      wr_data_d  = HRDATA;
      if (dp_beat_q == 2'd0) begin
        fw_valid_d  = 1'b1;
        fill_word_d = HRDATA;
      end
      if (dp_beat_q == LAST_BEAT) begin
        done_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (miss_ack) begin
          addr_hi_d  = miss_addr[31:4];
          w0_d       = miss_addr[3:2];
          beat_d     = '0;
          dp_valid_d = 1'b0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (data_err) begin
          state_d = ST_ABORT;
        end else if (HREADY) begin
          dp_valid_d = 1'b1;
          dp_beat_d  = beat_q;
          beat_d     = beat_q + 2'd1;
          if (beat_q == LAST_BEAT) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (data_err) begin
          state_d = ST_ABORT;
        end else if (data_ok) begin
          state_d = ST_IDLE;
        end
      end
      ST_ABORT: begin
        if (HREADY) begin
          dp_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    miss_ack = 1'b0;
    busy     = 1'b0;
    fill_err = 1'b0;
    HADDR    = '0;
    HTRANS   = HTRANS_IDLE;
    HBURST   = '0;
    HSIZE    = '0;

    unique case (state_q)
      // The last SRAM write shares the fill_done cycle and still needs addr_hi_q,
      // so a new request is only accepted one cycle later.
      ST_IDLE: miss_ack = miss_req && !done_q;
      ST_ADDR: begin
        busy   = 1'b1;
        HBURST = HBURST_WRAP4;
        HSIZE  = HSIZE_WORD;
        HADDR  = {addr_hi_q, w0_q + beat_q, 2'b00};
        if (data_err) begin
          HTRANS = HTRANS_IDLE;
        end else begin
          HTRANS = (beat_q == 2'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
        end
      end
      ST_DRAIN: begin
        busy   = 1'b1;
        HBURST = HBURST_WRAP4;
        HSIZE  = HSIZE_WORD;
      end
      ST_ABORT: begin
        busy     = !HREADY;
        fill_err = HREADY;
        HBURST   = HBURST_WRAP4;
        HSIZE    = HSIZE_WORD;
      end
      default: busy = 1'b0;
    endcase
  end

  assign HWRITE          = 1'b0;
  assign fill_word_valid = fw_valid_q;
  assign fill_word       = fill_word_q;
  assign fill_done       = done_q;
  assign sram_wr_en      = wr_en_q;
  assign sram_wr_data    = wr_data_q;
  assign sram_wr_addr    = {addr_hi_q[INDEX_WIDTH-1:0], wr_word_q};
  assign sram_wr_byte_en = {4{wr_en_q}};

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Bench for dcache_refill_ctrl: a wait-state/error-capable AHB slave plus a line-level
// reference model of the expected burst addresses, SRAM writes and completion timing.
module tb_dcache_refill_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        miss_req = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        miss_ack, busy, fill_word_valid, fill_done, fill_err;
  logic [31:0] fill_word, HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST, HSIZE;
  logic        HWRITE;
  logic        HREADY = 1'b1;
  logic        HRESP = 1'b0;
  logic [31:0] HRDATA = '0;
  logic [8:0]  sram_wr_addr;
  logic [31:0] sram_wr_data;
  logic        sram_wr_en;
  logic [3:0]  sram_wr_byte_en;

  dcache_refill_ctrl dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_ack(miss_ack), .busy(busy),
    .fill_word_valid(fill_word_valid), .fill_word(fill_word),
    .fill_done(fill_done), .fill_err(fill_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWRITE(HWRITE),
    .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA),
    .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .sram_wr_en(sram_wr_en), .sram_wr_byte_en(sram_wr_byte_en)
  );

  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Slave configuration: wait states per beat, errored beat (4 = none), line contents by word.
  int          wait_plan[4];
  int          err_beat = 4;
  logic [31:0] mem[4];

  // Observation logs.
  logic [31:0] acc_addr_q[$];
  logic [1:0]  acc_trans_q[$];
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [3:0]  wr_be_q[$];
  int          wr_cyc_q[$];
  int          ack_q[$];
  int          done_q[$];
  int          err_q[$];
  logic [31:0] fw_q[$];
  int          err_idle_seen = 0;

  bit          dp_active = 0;
  logic [31:0] dp_addr = '0;
  int          dp_beat = 0;
  int          dp_wait = 0;
  bit          err_phase = 0;
  logic [1:0]  s_htrans = '0;
  logic [31:0] s_haddr = '0;
  bit          prev_nonidle = 0;
  bit          prev_ready = 1;
  logic [1:0]  prev_trans = '0;
  logic [31:0] prev_addr = '0;

  initial forever begin
    @(posedge HCLK);
    cyc++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    acc_addr_q.delete(); acc_trans_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_be_q.delete(); wr_cyc_q.delete();
    ack_q.delete(); done_q.delete(); err_q.delete(); fw_q.delete();
    err_idle_seen = 0;
  endtask

  task automatic monitor_sample();
    s_htrans = HTRANS;
    s_haddr  = HADDR;
    if (!HRESETn) begin
      prev_nonidle = 0;
      return;
    end
    if (prev_nonidle && !prev_ready && !HRESP) begin
      tests++;
      if ({HTRANS, HADDR} !== {prev_trans, prev_addr}) begin
        fails++;
        $display("FAIL hold: got trans %b addr %h want trans %b addr %h",
                 HTRANS, HADDR, prev_trans, prev_addr);
      end
    end
    if (HRESP && !HREADY) begin
      tests++;
      err_idle_seen++;
      if (HTRANS !== 2'b00) begin
        fails++;
        $display("FAIL err_htrans: got %b want 00", HTRANS);
      end
    end
    if (HTRANS[1] && HREADY) begin
      acc_addr_q.push_back(HADDR);
      acc_trans_q.push_back(HTRANS);
    end
    if (miss_ack) ack_q.push_back(cyc);
    if (sram_wr_en) begin
      wr_addr_q.push_back(int'(sram_wr_addr));
      wr_data_q.push_back(sram_wr_data);
      wr_be_q.push_back(sram_wr_byte_en);
      wr_cyc_q.push_back(cyc);
    end
    if (fill_word_valid) fw_q.push_back(fill_word);
    if (fill_done) begin
      done_q.push_back(cyc);
      tests++;
      if (sram_wr_en !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL done_cycle: got wr_en %b busy %b want 1 0", sram_wr_en, busy);
      end
    end
    if (fill_err) begin
      err_q.push_back(cyc);
      tests++;
      if (busy !== 1'b0 || fill_done !== 1'b0) begin
        fails++;
        $display("FAIL err_cycle: got busy %b done %b want 0 0", busy, fill_done);
      end
    end
    prev_nonidle = HTRANS[1];
    prev_ready   = HREADY;
    prev_trans   = HTRANS;
    prev_addr    = HADDR;
  endtask

  // AHB slave: drives the response just after the falling edge, then samples the DUT 2ns
  // before the rising edge.
  initial forever begin
    @(negedge HCLK);
    if (!HRESETn) begin
      dp_active = 0; err_phase = 0; HREADY = 1'b1; HRESP = 1'b0; s_htrans = '0;
    end else begin
      if (dp_active && HREADY) dp_active = 0;
      if (HREADY && s_htrans[1]) begin
        dp_beat   = (s_htrans == 2'b10) ? 0 : dp_beat + 1;
        dp_active = 1;
        dp_addr   = s_haddr;
        dp_wait   = wait_plan[dp_beat & 3];
        err_phase = 0;
      end
      HRESP  = 1'b0;
      HREADY = 1'b1;
      HRDATA = $urandom;
      if (dp_active) begin
        if (dp_wait > 0) begin
          HREADY = 1'b0;
          dp_wait--;
        end else if (dp_beat == err_beat) begin
          HRESP     = 1'b1;
          HREADY    = err_phase;
          err_phase = 1;
        end else begin
          HRDATA = mem[dp_addr[3:2]];
        end
      end
    end
    #3;
    monitor_sample();
  end

  function automatic logic [31:0] exp_haddr(input logic [31:0] a, input int k);
    return (a & 32'hFFFF_FFF0) | (((((a >> 2) & 3) + k) % 4) << 2);
  endfunction

  function automatic int exp_sram(input logic [31:0] a, input int j);
    return int'((a >> 4) & 32'h7F) * 4 + int'((((a >> 2) & 3) + j) % 4);
  endfunction

  task automatic randomize_line();
    for (int i = 0; i < 4; i++) mem[i] = $urandom;
  endtask

  // One complete refill, compared against the line-level model.
  task automatic run_refill(input logic [31:0] addr, input string tag);
    int bound, sum_w, n_acc, n_wr, w0;
    clear_logs();
    w0 = int'((addr >> 2) & 3);
    sum_w = wait_plan[0] + wait_plan[1] + wait_plan[2] + wait_plan[3];
    n_acc = (err_beat < 4) ? err_beat + 1 : 4;
    n_wr  = (err_beat < 4) ? err_beat : 4;
    @(negedge HCLK);
    miss_req  = 1'b1;
    miss_addr = addr;
    bound = 0;
    forever begin
      #4;
      if (ack_q.size() != 0 || bound >= 20) break;
      @(negedge HCLK);
      bound++;
    end
    @(negedge HCLK);
    miss_req = 1'b0;
    bound = 0;
    while (done_q.size() + err_q.size() == 0 && bound < 100) begin
      @(negedge HCLK);
      bound++;
    end
    repeat (3) @(negedge HCLK);

    tests++;
    if (ack_q.size() != 1) begin
      fails++;
      $display("FAIL %s ack_count: got %0d want 1", tag, ack_q.size());
    end
    tests++;
    if (acc_addr_q.size() != n_acc) begin
      fails++;
      $display("FAIL %s addr_count: got %0d want %0d", tag, acc_addr_q.size(), n_acc);
    end
    for (int k = 0; k < n_acc && k < acc_addr_q.size(); k++) begin
      tests++;
      if (acc_addr_q[k] !== exp_haddr(addr, k) || acc_trans_q[k] !== ((k == 0) ? 2'b10 : 2'b11)) begin
        fails++;
        $display("FAIL %s haddr[%0d]: got %h/%b want %h/%b", tag, k, acc_addr_q[k],
                 acc_trans_q[k], exp_haddr(addr, k), (k == 0) ? 2'b10 : 2'b11);
      end
    end
    tests++;
    if (wr_addr_q.size() != n_wr) begin
      fails++;
      $display("FAIL %s write_count: got %0d want %0d", tag, wr_addr_q.size(), n_wr);
    end
    for (int j = 0; j < n_wr && j < wr_addr_q.size(); j++) begin
      tests++;
      if (wr_addr_q[j] != exp_sram(addr, j) || wr_data_q[j] !== mem[(w0 + j) % 4] ||
          wr_be_q[j] !== 4'hF) begin
        fails++;
        $display("FAIL %s write[%0d]: got %h/%h/%h want %h/%h/f", tag, j, wr_addr_q[j],
                 wr_data_q[j], wr_be_q[j], exp_sram(addr, j), mem[(w0 + j) % 4]);
      end
    end
    tests++;
    if (fw_q.size() != ((n_wr > 0) ? 1 : 0) || (n_wr > 0 && fw_q.size() == 1 && fw_q[0] !== mem[w0])) begin
      fails++;
      $display("FAIL %s fill_word_valid: got %0d pulses want %0d (data want %h)", tag,
               fw_q.size(), (n_wr > 0) ? 1 : 0, mem[w0]);
    end
    if (n_wr > 0) begin
      tests++;
      if (fill_word !== mem[w0]) begin
        fails++;
        $display("FAIL %s fill_word_hold: got %h want %h", tag, fill_word, mem[w0]);
      end
    end
    tests++;
    if (done_q.size() != ((err_beat < 4) ? 0 : 1) || err_q.size() != ((err_beat < 4) ? 1 : 0)) begin
      fails++;
      $display("FAIL %s completion: got done %0d err %0d want done %0d err %0d", tag,
               done_q.size(), err_q.size(), (err_beat < 4) ? 0 : 1, (err_beat < 4) ? 1 : 0);
    end
    if (err_beat >= 4 && done_q.size() == 1 && ack_q.size() == 1) begin
      tests++;
      if (done_q[0] - ack_q[0] != 6 + sum_w) begin
        fails++;
        $display("FAIL %s latency: got %0d want %0d", tag, done_q[0] - ack_q[0], 6 + sum_w);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    tests++;
    if ({miss_ack, busy, fill_word_valid, fill_word, fill_done, fill_err, HADDR, HTRANS,
         HBURST, HSIZE, HWRITE, sram_wr_addr, sram_wr_data, sram_wr_en, sram_wr_byte_en} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy %b htrans %b haddr %h wr_en %b fill_word %h want all 0",
               busy, HTRANS, HADDR, sram_wr_en, fill_word);
    end
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    #4;
    tests++;
    if (busy !== 1'b0 || HTRANS !== 2'b00 || miss_ack !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy %b htrans %b ack %b want 0 00 0", busy, HTRANS, miss_ack);
    end
  endtask

  task automatic test_zero_wait();
    int exp_h[4] = '{32'h2000_0048, 32'h2000_004C, 32'h2000_0040, 32'h2000_0044};
    int exp_s[4] = '{32'h012, 32'h013, 32'h010, 32'h011};
    wait_plan = '{0, 0, 0, 0};
    err_beat = 4;
    randomize_line();
    run_refill(32'h2000_0048, "zero_wait");
    for (int i = 0; i < 4 && i < acc_addr_q.size() && i < wr_addr_q.size(); i++) begin
      tests++;
      if (acc_addr_q[i] !== exp_h[i] || wr_addr_q[i] != exp_s[i]) begin
        fails++;
        $display("FAIL zero_wait_const[%0d]: got %h/%h want %h/%h", i, acc_addr_q[i],
                 wr_addr_q[i], exp_h[i], exp_s[i]);
      end
    end
    if (wr_cyc_q.size() == 4 && done_q.size() == 1) begin
      tests++;
      if (wr_cyc_q[3] - wr_cyc_q[0] != 3 || done_q[0] != wr_cyc_q[3]) begin
        fails++;
        $display("FAIL zero_wait_spacing: got span %0d done@%0d want span 3 done@%0d",
                 wr_cyc_q[3] - wr_cyc_q[0], done_q[0], wr_cyc_q[3]);
      end
    end
  endtask

  task automatic test_wait_states();
    wait_plan = '{0, 2, 0, 0};
    err_beat = 4;
    randomize_line();
    run_refill(32'h2000_0048, "wait_beat1");
  endtask

  task automatic test_error();
    wait_plan = '{0, 0, 0, 0};
    err_beat = 2;
    randomize_line();
    run_refill(32'h2000_0048, "error_beat2");
    tests++;
    if (wr_addr_q.size() != 2 || (wr_addr_q.size() == 2 && (wr_addr_q[0] != 'h012 || wr_addr_q[1] != 'h013))) begin
      fails++;
      $display("FAIL error_words: got %0d writes want 2 at 012,013", wr_addr_q.size());
    end
    tests++;
    if (err_idle_seen != 1) begin
      fails++;
      $display("FAIL error_first_cycle: got %0d want 1", err_idle_seen);
    end
    err_beat = 4;
  endtask

  task automatic test_back_to_back();
    int bound, acks_at_done;
    logic [31:0] a2 = 32'h3000_0174;
    wait_plan = '{0, 1, 0, 0};
    err_beat = 4;
    randomize_line();
    clear_logs();
    acks_at_done = -1;
    @(negedge HCLK);
    miss_req  = 1'b1;
    miss_addr = 32'h2000_0048;
    bound = 0;
    while (ack_q.size() == 0 && bound < 20) begin @(negedge HCLK); bound++; end
    @(negedge HCLK);
    miss_addr = a2;
    bound = 0;
    while (done_q.size() == 0 && bound < 100) begin @(negedge HCLK); bound++; end
    acks_at_done = ack_q.size();
    bound = 0;
    while (ack_q.size() < 2 && bound < 20) begin @(negedge HCLK); bound++; end
    @(negedge HCLK);
    miss_req = 1'b0;
    bound = 0;
    while (done_q.size() < 2 && bound < 100) begin @(negedge HCLK); bound++; end
    repeat (3) @(negedge HCLK);

    tests++;
    if (acks_at_done != 1) begin
      fails++;
      $display("FAIL b2b_single_ack: got %0d want 1", acks_at_done);
    end
    tests++;
    if (ack_q.size() != 2 || done_q.size() != 2 || (ack_q.size() == 2 && done_q.size() >= 1 && ack_q[1] < done_q[0] + 1)) begin
      fails++;
      $display("FAIL b2b_second_ack: got acks %0d dones %0d want 2 2, second ack after first done",
               ack_q.size(), done_q.size());
    end
    tests++;
    if (acc_addr_q.size() != 8 || (acc_addr_q.size() == 8 && acc_addr_q[4] !== exp_haddr(a2, 0))) begin
      fails++;
      $display("FAIL b2b_new_addr: got %0d addrs want 8, beat0 %h", acc_addr_q.size(), exp_haddr(a2, 0));
    end
    tests++;
    if (wr_addr_q.size() != 8 || (wr_addr_q.size() == 8 && (wr_addr_q[4] != 'h05D || wr_addr_q[7] != 'h05C))) begin
      fails++;
      $display("FAIL b2b_writes: got %0d writes want 8 with 05d..05c", wr_addr_q.size());
    end
  endtask

  task automatic test_async_reset();
    int bound;
    int exp_h[4] = '{32'h2000_0040, 32'h2000_0044, 32'h2000_0048, 32'h2000_004C};
    wait_plan = '{0, 0, 0, 0};
    err_beat = 4;
    randomize_line();
    clear_logs();
    @(negedge HCLK);
    miss_req  = 1'b1;
    miss_addr = 32'h2000_0088;
    bound = 0;
    forever begin
      #4;
      if (ack_q.size() != 0 || bound >= 20) break;
      @(negedge HCLK);
      bound++;
    end
    @(posedge HCLK);
    #1 miss_req = 1'b0;
    repeat (2) @(posedge HCLK);
    #2;
    tests++;
    if (busy !== 1'b1 || sram_wr_en !== 1'b1 || HTRANS !== 2'b11) begin
      fails++;
      $display("FAIL pre_reset: got busy %b wr_en %b htrans %b want 1 1 11", busy, sram_wr_en, HTRANS);
    end
    HRESETn = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || sram_wr_en !== 1'b0 || HTRANS !== 2'b00 || fill_done !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got busy %b wr_en %b htrans %b done %b want 0 0 00 0",
               busy, sram_wr_en, HTRANS, fill_done);
    end
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (2) @(negedge HCLK);
    run_refill(32'h2000_0040, "post_reset");
    for (int i = 0; i < 4 && i < acc_addr_q.size(); i++) begin
      tests++;
      if (acc_addr_q[i] !== exp_h[i]) begin
        fails++;
        $display("FAIL post_reset_haddr[%0d]: got %h want %h", i, acc_addr_q[i], exp_h[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 4; i++) wait_plan[i] = $urandom_range(0, 2);
      err_beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 4;
      randomize_line();
      a = $urandom & 32'hFFFF_FFFC;
      run_refill(a, $sformatf("random%0d", it));
    end
    err_beat = 4;
  endtask

  initial begin
    wait_plan = '{0, 0, 0, 0};
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_error();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_refill_ctrl.md
Name: dcache_refill_ctrl

Overview:
Line-refill engine that sits directly upstream of the D-cache data SRAM write port (512 x 32, byte-enabled). On a cache miss it issues an AHB-Lite WRAP4 read burst, critical word first. It writes each returned beat into the data SRAM and forwards the critical word to the load path. Tag/valid update is owned by the cache controller, which is triggered by fill_done.

Parameters:
INDEX_WIDTH, 7, cache line index bits taken from miss_addr[INDEX_WIDTH+3:4]
SRAM_ADDR_WIDTH, 9, data SRAM word address width; must equal INDEX_WIDTH+2
LINE_WORDS, 4, words per line; fixed at 4 (WRAP4)

Ports:
HCLK  in  1  single clock
HRESETn  in  1  reset, asynchronous, active-low
miss_req  in  1  refill request; held high until miss_ack
miss_addr  in  32  byte address of the missing word; sampled on miss_ack
miss_ack  out  1  one-cycle pulse: request accepted
busy  out  1  refill in progress
fill_word_valid  out  1  one-cycle pulse: fill_word holds the critical word
fill_word  out  32  critical word data
fill_done  out  1  one-cycle pulse: whole line written
fill_err  out  1  one-cycle pulse: burst aborted on HRESP error
HADDR  out  32  AHB address
HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11 (BUSY never driven)
HBURST  out  3  constant 3'b010 (WRAP4) during a burst
HSIZE  out  3  constant 3'b010
HWRITE  out  1  constant 0
HREADY  in  1  AHB ready
HRESP  in  1  AHB error response
HRDATA  in  32  AHB read data
sram_wr_addr  out  SRAM_ADDR_WIDTH  {index, word}
sram_wr_data  out  32  registered beat data
sram_wr_en  out  1  SRAM write strobe
sram_wr_byte_en  out  4  always 4'hF when writing

Behaviour:
- Reset values: all outputs 0. HTRANS=IDLE, state IDLE.
- FSM states: IDLE, ADDR, DRAIN, ABORT.
  - IDLE: when miss_req=1, pulse miss_ack, latch miss_addr, then go to ADDR. busy=1 from the next cycle.
  - ADDR: drive address beat k (k=0..3), HADDR={miss_addr[31:4], (w0+k) mod 4, 2'b00}, where w0=miss_addr[3:2].
    - k=0 uses NONSEQ; k>0 uses SEQ.
    - Address and control are held while HREADY=0.
    - Beat k advances on HREADY=1. After beat 3 is accepted, drive HTRANS=IDLE and go to DRAIN.
  - DRAIN: wait for the final data phase, then return to IDLE.
- Data phase for beat j completes on HREADY=1 and HRESP=0. On the next cycle:
  - sram_wr_en=1, sram_wr_data=captured HRDATA
  - sram_wr_addr={latched index, (w0+j) mod 4}
- Critical word:
  - fill_word_valid pulses in the same cycle as the j=0 SRAM write.
  - fill_word holds that data until the next refill.
- fill_done pulses in the same cycle as the j=3 SRAM write. busy drops the same cycle.
- Earliest next miss_ack is the cycle after fill_done. miss_req while busy is ignored, not queued.
- Error handling:
  - HRESP=1 with HREADY=0 (first error cycle): HTRANS=IDLE that same cycle, go to ABORT.
  - The errored beat and all later beats are never written.
  - fill_err pulses on the second error cycle (HREADY=1). busy drops the same cycle, then return to IDLE.
- Exactly one of fill_done or fill_err per accepted request.
- Asynchronous HRESETn assertion mid-burst: state to IDLE and all outputs to reset values immediately. No partial-line indication beyond the loss of fill_done.
- Write/read hazard: refilled words are readable on the SRAM read port from the cycle after their write. The controller must not issue a hit to this line before fill_done.

Test Plan:
- Zero-wait, miss_addr=0x2000_0048 ->
  - HADDR 0x2000_0048, 0x2000_004C, 0x2000_0040, 0x2000_0044 with HTRANS NONSEQ, SEQ, SEQ, SEQ.
  - sram_wr_addr 0x012, 0x013, 0x010, 0x011 on 4 consecutive cycles, byte_en 4'hF.
  - fill_word=first HRDATA. fill_done with the 4th write.
- HREADY=0 for 2 cycles during the beat-1 data phase -> HADDR/HTRANS held stable. Exactly 4 SRAM writes, no duplicates. fill_done delayed by 2 cycles.
- HRESP error on beat 2 -> writes only for word offsets 2 and 3 (beats 0,1). HTRANS=IDLE in the first error cycle. fill_err pulses once, no fill_done.
- miss_req held high through a refill -> a single miss_ack. A second miss_ack comes no earlier than the cycle after fill_done, with new miss_addr latched.
- HRESETn asserted mid-ADDR state -> HTRANS, sram_wr_en and busy go to 0 asynchronously. A subsequent miss at 0x2000_0040 completes normally (HADDR 0x40, 0x44, 0x48, 0x4C).
